// File: rtl/regfile_wr_arbiter.sv
// rtl/regfile_wr_arbiter.sv - two-port register-file writeback arbiter with read forwarding
module regfile_wr_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  output logic        alu_ready,
  input  logic        mem_valid,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_data,
  output logic        mem_ready,
  output logic        write_en,
  output logic [4:0]  WriteAdd,
  output logic [31:0] Reg_WriteData,
  input  logic [4:0]  ReadAdd1,
  input  logic [4:0]  ReadAdd2,
  input  logic [31:0] RegData1,
  input  logic [31:0] RegData2,
  output logic [31:0] Data1,
  output logic [31:0] Data2,
  output logic [15:0] wr_count
);

  typedef enum logic {PRI_MEM = 1'b0, PRI_ALU = 1'b1} pri_t;

  pri_t        pri_q;
  pri_t        pri_d;
  logic        we_q;
  logic        alu_xfer;
  logic        mem_xfer;
  logic        any_xfer;
  logic [4:0]  xfer_rd;
  logic [31:0] xfer_data;
  logic        fwd1;
  logic        fwd2;

  // Priority state register; reset favours the load port.
  always_ff @(posedge clk) begin
    if (!rst_n) pri_q <= PRI_MEM;
    else        pri_q <= pri_d;
  end

  // Next priority: only a contended cycle hands priority to the loser.
  always_comb begin
    pri_d = pri_q;
    if (alu_valid && mem_valid)
      pri_d = (pri_q == PRI_MEM) ? PRI_ALU : PRI_MEM;
  end

  // Grant outputs: a lone requester always wins, contention goes to the priority holder.
  always_comb begin
    alu_ready = 1'b0;
    mem_ready = 1'b0;
    if (rst_n) begin
      if (alu_valid && mem_valid) begin
        alu_ready = (pri_q == PRI_ALU);
        mem_ready = (pri_q == PRI_MEM);
      end else begin
        alu_ready = alu_valid;
        mem_ready = mem_valid;
      end
    end
  end

  assign alu_xfer  = alu_valid && alu_ready;
  assign mem_xfer  = mem_valid && mem_ready;
  assign any_xfer  = alu_xfer || mem_xfer;
  assign xfer_rd   = mem_xfer ? mem_rd : alu_rd;
  assign xfer_data = mem_xfer ? mem_data : alu_data;

  // Writeback output register; x0 writes are accepted but never enabled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we_q          <= 1'b0;
      WriteAdd      <= 5'd0;
      Reg_WriteData <= 32'd0;
    end else begin
      we_q <= any_xfer && (xfer_rd != 5'd0);
      if (any_xfer) begin
        WriteAdd      <= xfer_rd;
        Reg_WriteData <= xfer_data;
      end
    end
  end

  // A write still pending when reset arrives is dropped rather than committed.
  assign write_en = we_q && rst_n;

  // Saturating count of committed non-x0 writes.
  always_ff @(posedge clk) begin
    if (!rst_n)
      wr_count <= 16'd0;
    else if (write_en && (wr_count != 16'hFFFF))
      wr_count <= wr_count + 16'd1;
  end

  assign fwd1 = write_en && (WriteAdd == ReadAdd1) && (ReadAdd1 != 5'd0);
  assign fwd2 = write_en && (WriteAdd == ReadAdd2) && (ReadAdd2 != 5'd0);

  // Bypass the in-flight write so readers see it in the same cycle it is committed.
  always_comb begin
    Data1 = fwd1 ? Reg_WriteData : RegData1;
    Data2 = fwd2 ? Reg_WriteData : RegData2;
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb/tb_regfile_wr_arbiter.sv - self-checking bench for regfile_wr_arbiter
module tb_regfile_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid, mem_valid;
  logic [4:0]  alu_rd, mem_rd;
  logic [31:0] alu_data, mem_data;
  logic        alu_ready, mem_ready;
  logic        write_en;
  logic [4:0]  WriteAdd;
  logic [31:0] Reg_WriteData;
  logic [4:0]  ReadAdd1, ReadAdd2;
  logic [31:0] RegData1, RegData2;
  logic [31:0] Data1, Data2;
  logic [15:0] wr_count;

  int checks = 0;
  int errors = 0;

  // register_set stand-in driven by the DUT write port
  logic [31:0] rf [32];
  // bench model state
  logic [31:0] mrf [32];
  logic        m_pri;
  logic        m_we;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;
  logic [15:0] m_cnt;
  logic        m_ga, m_gm;

  regfile_wr_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .write_en(write_en), .WriteAdd(WriteAdd), .Reg_WriteData(Reg_WriteData),
    .ReadAdd1(ReadAdd1), .ReadAdd2(ReadAdd2), .RegData1(RegData1), .RegData2(RegData2),
    .Data1(Data1), .Data2(Data2), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (write_en && WriteAdd != 5'd0) rf[WriteAdd] <= Reg_WriteData;
  end

  assign RegData1 = rf[ReadAdd1];
  assign RegData2 = rf[ReadAdd2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (a != 5'd0 && m_we && rst_n && m_wa == a) return m_wd;
    return mrf[a];
  endfunction

  // One clock cycle: drive at negedge, check combinational and registered outputs, advance model.
  task automatic cyc(input logic rst, input logic av, input logic [4:0] ard, input logic [31:0] ad,
                     input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                     input logic [4:0] ra1, input logic [4:0] ra2);
    logic [4:0]  g_rd;
    logic [31:0] g_d;
    @(negedge clk);
    rst_n = rst; alu_valid = av; alu_rd = ard; alu_data = ad;
    mem_valid = mv; mem_rd = mrd; mem_data = md; ReadAdd1 = ra1; ReadAdd2 = ra2;
    #1;
    m_ga = 1'b0; m_gm = 1'b0;
    if (rst) begin
      if (av && mv) begin m_ga = m_pri; m_gm = !m_pri; end
      else begin m_ga = av; m_gm = mv; end
    end
    chk("alu_ready", alu_ready, m_ga);
    chk("mem_ready", mem_ready, m_gm);
    chk("write_en", write_en, m_we && rst);
    if (m_we && rst) begin
      chk("WriteAdd", WriteAdd, m_wa);
      chk("Reg_WriteData", Reg_WriteData, m_wd);
    end
    chk("wr_count", wr_count, m_cnt);
    chk("Data1", Data1, exp_rd(ra1));
    chk("Data2", Data2, exp_rd(ra2));
    if (!rst) begin
      m_we = 1'b0; m_wa = 5'd0; m_wd = 32'd0; m_cnt = 16'd0; m_pri = 1'b0;
    end else begin
      if (m_we && m_wa != 5'd0) mrf[m_wa] = m_wd;
      if (m_we && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      g_rd = m_gm ? mrd : ard;
      g_d  = m_gm ? md : ad;
      m_we = (m_ga || m_gm) && g_rd != 5'd0;
      if (m_ga || m_gm) begin m_wa = g_rd; m_wd = g_d; end
      if (av && mv) m_pri = !m_pri;
    end
  endtask

  task automatic idle(input logic [4:0] ra1);
    cyc(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, ra1, 5'd0);
  endtask

  initial begin
    logic a_hold, m_hold;
    logic av, mv;
    logic [4:0] ard, mrd;
    logic [31:0] ad, md;
    for (int i = 0; i < 32; i++) begin rf[i] = 32'd0; mrf[i] = 32'd0; end
    m_pri = 1'b0; m_we = 1'b0; m_wa = 5'd0; m_wd = 32'd0; m_cnt = 16'd0;
    rst_n = 1'b0; alu_valid = 1'b0; mem_valid = 1'b0; alu_rd = 5'd0; mem_rd = 5'd0;
    alu_data = 32'd0; mem_data = 32'd0; ReadAdd1 = 5'd0; ReadAdd2 = 5'd0;

    // reset, with requests presented that must not be accepted
    cyc(1'b0, 1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44, 5'd0, 5'd0);
    cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    chk("reset write_en", write_en, 1'b0);
    chk("reset wr_count", wr_count, 16'd0);
    chk("reset WriteAdd", WriteAdd, 5'd0);

    // single ALU write with same-cycle forwarding then register_set read
    cyc(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 5'd5, 5'd5);
    chk("alu single ready", alu_ready, 1'b1);
    idle(5'd5);
    chk("alu wr WriteAdd", WriteAdd, 5'd5);
    chk("alu fwd Data1", Data1, 32'hDEADBEEF);
    idle(5'd5);
    chk("alu reg Data1", Data1, 32'hDEADBEEF);
    chk("alu count", wr_count, 16'd1);

    // x0 write is accepted but never enabled
    cyc(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h12345678, 5'd0, 5'd0);
    chk("x0 ready", mem_ready, 1'b1);
    idle(5'd0);
    chk("x0 write_en", write_en, 1'b0);
    chk("x0 Data1", Data1, 32'd0);
    chk("x0 count", wr_count, 16'd1);

    // same-rd collision from PRI_MEM: mem (2) first, alu (1) last
    cyc(1'b1, 1'b1, 5'd7, 32'h1, 1'b1, 5'd7, 32'h2, 5'd7, 5'd0);
    chk("coll mem first", mem_ready, 1'b1);
    chk("coll alu wait", alu_ready, 1'b0);
    cyc(1'b1, 1'b1, 5'd7, 32'h1, 1'b0, 5'd0, 32'd0, 5'd7, 5'd7);
    chk("coll alu second", alu_ready, 1'b1);
    chk("coll first data", Data1, 32'h2);
    idle(5'd7);
    chk("coll second data", Reg_WriteData, 32'h1);
    idle(5'd7);
    chk("coll final reg7", Data1, 32'h1);
    chk("coll count", wr_count, 16'd3);

    // contention after reset: MEM,ALU,MEM,ALU...
    cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b1, 5'(1 + i / 2), 32'hA000 + 32'(i / 2), 1'b1, 5'(9 + (i + 1) / 2),
          32'hB000 + 32'((i + 1) / 2), 5'(1 + i / 2), 5'(9 + i / 2));
      chk("cont mem grant", mem_ready, (i % 2) == 0);
    end
    idle(5'd4);
    chk("cont last fwd", Data1, 32'hA003);
    idle(5'd12);
    chk("cont count", wr_count, 16'd8);
    chk("cont reg12", Data1, 32'hB003);

    // reset in the cycle after a transfer cancels the pending write
    cyc(1'b1, 1'b1, 5'd20, 32'hAA, 1'b0, 5'd0, 32'd0, 5'd20, 5'd0);
    cyc(1'b0, 1'b1, 5'd21, 32'hBB, 1'b0, 5'd0, 32'd0, 5'd20, 5'd0);
    chk("rst cancel we", write_en, 1'b0);
    chk("rst no accept", alu_ready, 1'b0);
    cyc(1'b1, 1'b1, 5'd22, 32'hCC, 1'b1, 5'd23, 32'hDD, 5'd20, 5'd0);
    chk("rst reg20 kept", Data1, 32'd0);
    chk("rst count", wr_count, 16'd0);
    chk("rst pri mem", mem_ready, 1'b1);
    cyc(1'b1, 1'b1, 5'd22, 32'hCC, 1'b0, 5'd0, 32'd0, 5'd23, 5'd23);
    idle(5'd22);

    // randomized regression with held losing requests
    a_hold = 1'b0; m_hold = 1'b0;
    av = 1'b0; mv = 1'b0; ard = 5'd0; mrd = 5'd0; ad = 32'd0; md = 32'd0;
    for (int i = 0; i < 10000; i++) begin
      if (!a_hold) begin av = 1'($urandom_range(0, 1)); ard = 5'($urandom_range(0, 7)); ad = $urandom; end
      if (!m_hold) begin mv = 1'($urandom_range(0, 1)); mrd = 5'($urandom_range(0, 7)); md = $urandom; end
      cyc(1'b1, av, ard, ad, mv, mrd, md, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      a_hold = av && !m_ga;
      m_hold = mv && !m_gm;
    end
    idle(5'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
